// File: rtl/char_buf_pkg.sv
// Shared definitions for the character buffer in data RAM.
// The host write path and the read-out engine both use these constants.
package char_buf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } rd_state_t;

   localparam int CHAR_BUF_BASE = 1500;
   localparam int CHAR_BUF_LEN  = 108;
   localparam logic [7:0] CHAR_NUL = 8'h00;

   // Character counter stops at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/char_buffer_reader.sv
// Streams the low byte of each char-buffer RAM word out over a valid/ready byte port.
// Optional CHAR_READER_NUL_STOP_EN: a 0x00 byte ends the run early and is not emitted.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | present BASE_ADDR+idx to RAM
// WAIT  | RAM read latency; capture low byte at the closing edge
// SEND  | char_valid high until the sink accepts
// DONE  | one-cycle done pulse
module char_buffer_reader
   import char_buf_pkg::*;
#(
   parameter int BASE_ADDR = CHAR_BUF_BASE,
   parameter int BUF_LEN   = CHAR_BUF_LEN,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [7:0]        char_data,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              busy,
   output logic              done,
   output logic [7:0]        char_count
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUF_LEN - 1);

   // The whole buffer must be addressable without wrapping.
   if (BUF_LEN < 1 || (BASE_ADDR + BUF_LEN) > (1 << ADDR_W)) begin : g_bad_range
      $error("char_buffer_reader: BASE_ADDR+BUF_LEN does not fit in ADDR_W");
   end

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        char_q;
   logic [7:0]        count_q;
   logic              unused_hi;

   assign unused_hi = ^mem_data[DATA_W-1:8];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_WAIT;
         ST_WAIT: begin
`ifdef CHAR_READER_NUL_STOP_EN
            if (mem_data[7:0] == CHAR_NUL) state_d = ST_DONE;
            else                           state_d = ST_SEND;
`else
            state_d = ST_SEND;
`endif
         end
         ST_SEND: begin
            if (char_ready) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         char_q  <= 8'h00;
         count_q <= 8'h00;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  idx_q   <= '0;
                  count_q <= 8'h00;
                  addr_q  <= BASE;
               end
            end
            ST_WAIT: begin
               if (state_d == ST_SEND) char_q <= mem_data[7:0];
            end
            ST_SEND: begin
               // Address only advances on a handshake and never past the last entry.
               if (char_ready) begin
                  count_q <= sat_inc8(count_q);
                  idx_q   <= idx_q + ADDR_W'(1);
                  if (idx_q != LAST_IDX) addr_q <= BASE + idx_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_rd_en  = (state_q == ST_FETCH) || (state_q == ST_WAIT);
   assign mem_addr   = addr_q;
   assign char_data  = char_q;
   assign char_valid = (state_q == ST_SEND);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign char_count = count_q;

endmodule

// File: tb/tb_char_buffer_reader.sv
// Directed bench: a 3-entry instance for the short scenarios and a default-length instance.
// Expected characters are queued when a run is started and popped on each handshake.
module tb_char_buffer_reader;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ram [0:4095];

   logic        s_start, s_rd_en, s_valid, s_ready, s_busy, s_done;
   logic [11:0] s_addr;
   logic [31:0] s_mem_data;
   logic [7:0]  s_char, s_count;

   logic        f_start, f_rd_en, f_valid, f_ready, f_busy, f_done;
   logic [11:0] f_addr;
   logic [31:0] f_mem_data;
   logic [7:0]  f_char, f_count;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [7:0]  q_s[$];
   logic [7:0]  q_f[$];
   int          s_hs_cyc[$];
   int          s_done_n = 0, f_done_n = 0, f_hs_n = 0;
   int          f_max_addr = 0, f_min_addr = 4095;
   bit          s_seen [0:4095];
   bit          f_seen [0:4095];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) s_mem_data <= ram[s_addr];
   always @(posedge clock) f_mem_data <= ram[f_addr];

   char_buffer_reader #(.BUF_LEN(3)) u_small (
      .clock(clock), .reset(reset), .start(s_start), .mem_rd_en(s_rd_en),
      .mem_addr(s_addr), .mem_data(s_mem_data), .char_data(s_char),
      .char_valid(s_valid), .char_ready(s_ready), .busy(s_busy),
      .done(s_done), .char_count(s_count));

   char_buffer_reader u_full (
      .clock(clock), .reset(reset), .start(f_start), .mem_rd_en(f_rd_en),
      .mem_addr(f_addr), .mem_data(f_mem_data), .char_data(f_char),
      .char_valid(f_valid), .char_ready(f_ready), .busy(f_busy),
      .done(f_done), .char_count(f_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input bit full, input int budget);
      int n = 0;
      while (!(full ? f_done : s_done) && n < budget) begin
         tick(1);
         n++;
      end
      chk(full ? "f_done_seen" : "s_done_seen", full ? f_done : s_done, 1'b1);
   endtask

   task automatic clear_seen();
      for (int a = 0; a < 4096; a++) begin
         s_seen[a] = 1'b0;
         f_seen[a] = 1'b0;
      end
   endtask

   // Monitor: handshakes happen at the next rising edge when valid&ready hold at the falling edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (s_valid && s_ready) begin
            s_hs_cyc.push_back(cyc);
            if (q_s.size() == 0) chk("s_unexpected_char", {24'h0, s_char}, 32'hFFFF_FFFF);
            else chk("s_char_data", {24'h0, s_char}, {24'h0, q_s.pop_front()});
         end
         if (f_valid && f_ready) begin
            f_hs_n++;
            if (q_f.size() == 0) chk("f_unexpected_char", {24'h0, f_char}, 32'hFFFF_FFFF);
            else chk("f_char_data", {24'h0, f_char}, {24'h0, q_f.pop_front()});
         end
         if (s_rd_en) s_seen[s_addr] = 1'b1;
         if (f_rd_en) begin
            f_seen[f_addr] = 1'b1;
            if (int'(f_addr) > f_max_addr) f_max_addr = int'(f_addr);
            if (int'(f_addr) < f_min_addr) f_min_addr = int'(f_addr);
         end
         if (s_done) s_done_n++;
         if (f_done) f_done_n++;
      end
   end

   initial begin
      int d0;
      for (int a = 0; a < 4096; a++) ram[a] = 32'hDEAD_BE41;
      ram[1500] = 32'hCAFE_0048;
      ram[1501] = 32'h1234_5649;
      ram[1502] = 32'hFFFF_FF21;
      clear_seen();
      reset = 1'b1; s_start = 0; f_start = 0; s_ready = 1; f_ready = 1;
      tick(2);
      chk("rst_rd_en", s_rd_en, 0);
      chk("rst_addr", s_addr, 0);
      chk("rst_char", s_char, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
      chk("rst_count", s_count, 0);
      reset = 1'b0;
      tick(1);

      // 1: three characters, sink always ready
      q_s.push_back(8'h48); q_s.push_back(8'h49); q_s.push_back(8'h21);
      s_hs_cyc.delete();
      d0 = s_done_n;
      s_start = 1; tick(1); s_start = 0;
      chk("t1_fetch_rd_en", s_rd_en, 1);
      chk("t1_fetch_addr", s_addr, 1500);
      chk("t1_fetch_valid", s_valid, 0);
      chk("t1_fetch_busy", s_busy, 1);
      tick(1);
      chk("t1_wait_rd_en", s_rd_en, 1);
      chk("t1_wait_addr", s_addr, 1500);
      tick(1);
      chk("t1_send_valid", s_valid, 1);
      chk("t1_send_char", s_char, 8'h48);
      chk("t1_send_rd_en", s_rd_en, 0);
      wait_done(0, 40);
      chk("t1_count", s_count, 3);
      tick(1);
      chk("t1_busy_after_done", s_busy, 0);
      chk("t1_done_after", s_done, 0);
      chk("t1_done_pulses", s_done_n - d0, 1);
      chk("t1_q_empty", q_s.size(), 0);
      chk("t1_hs_n", s_hs_cyc.size(), 3);
      if (s_hs_cyc.size() == 3) begin
         chk("t1_spacing0", s_hs_cyc[1] - s_hs_cyc[0], 3);
         chk("t1_spacing1", s_hs_cyc[2] - s_hs_cyc[1], 3);
      end

      // 2: backpressure in the first SEND
      q_s.push_back(8'h48); q_s.push_back(8'h49); q_s.push_back(8'h21);
      s_ready = 0;
      s_start = 1; tick(1); s_start = 0;
      tick(2);
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_valid", s_valid, 1);
         chk("t2_stall_char", s_char, 8'h48);
         chk("t2_stall_rd_en", s_rd_en, 0);
         chk("t2_stall_addr", s_addr, 1500);
         tick(1);
      end
      s_ready = 1;
      tick(1);
      chk("t2_after_hs_valid", s_valid, 0);
      chk("t2_after_hs_addr", s_addr, 1501);
      chk("t2_after_hs_count", s_count, 1);
      wait_done(0, 40);
      chk("t2_count", s_count, 3);
      tick(1);
      chk("t2_q_empty", q_s.size(), 0);

      // 3: NUL in the second entry
      ram[1501] = 32'hABCD_EF00;
      clear_seen();
`ifdef CHAR_READER_NUL_STOP_EN
      q_s.push_back(8'h48);
`else
      q_s.push_back(8'h48); q_s.push_back(8'h00); q_s.push_back(8'h21);
`endif
      s_start = 1; tick(1); s_start = 0;
      wait_done(0, 40);
`ifdef CHAR_READER_NUL_STOP_EN
      chk("t3_count_nul", s_count, 1);
      chk("t3_1502_unread", s_seen[1502], 0);
      chk("t3_1501_read", s_seen[1501], 1);
`else
      chk("t3_count", s_count, 3);
      chk("t3_1502_read", s_seen[1502], 1);
`endif
      tick(1);
      chk("t3_q_empty", q_s.size(), 0);
      ram[1501] = 32'h1234_5649;

      // 4: start pulses during SEND and DONE are ignored
      q_s.push_back(8'h48); q_s.push_back(8'h49); q_s.push_back(8'h21);
      d0 = s_done_n;
      s_start = 1; tick(1); s_start = 0;
      tick(2);
      chk("t4_in_send", s_valid, 1);
      s_start = 1; tick(1); s_start = 0;
      wait_done(0, 40);
      s_start = 1; tick(1); s_start = 0;
      tick(2);
      chk("t4_idle_busy", s_busy, 0);
      chk("t4_idle_rd_en", s_rd_en, 0);
      chk("t4_count", s_count, 3);
      chk("t4_done_pulses", s_done_n - d0, 1);
      chk("t4_q_empty", q_s.size(), 0);

      // 5: reset while stalled in SEND, then restart
      s_ready = 0;
      s_start = 1; tick(1); s_start = 0;
      tick(2);
      chk("t5_in_send", s_valid, 1);
      reset = 1; tick(1);
      chk("t5_rst_valid", s_valid, 0);
      chk("t5_rst_busy", s_busy, 0);
      chk("t5_rst_rd_en", s_rd_en, 0);
      chk("t5_rst_count", s_count, 0);
      chk("t5_rst_char", s_char, 0);
      reset = 0; s_ready = 1;
      tick(1);
      q_s.push_back(8'h48); q_s.push_back(8'h49); q_s.push_back(8'h21);
      s_start = 1; tick(1); s_start = 0;
      chk("t5_restart_addr", s_addr, 1500);
      chk("t5_restart_rd_en", s_rd_en, 1);
      wait_done(0, 40);
      chk("t5_count", s_count, 3);
      tick(1);
      chk("t5_q_empty", q_s.size(), 0);

      // 6: full-length run on the default instance
      for (int a = 0; a < 4096; a++) ram[a] = 32'hDEAD_BE41;
      clear_seen();
      for (int i = 0; i < 108; i++) q_f.push_back(8'h41);
      d0 = f_done_n;
      f_hs_n = 0;
      f_start = 1; tick(1); f_start = 0;
      wait_done(1, 500);
      chk("t6_count", f_count, 108);
      chk("t6_last_addr", f_addr, 1607);
      tick(2);
      chk("t6_hs_n", f_hs_n, 108);
      chk("t6_max_addr", f_max_addr, 1607);
      chk("t6_min_addr", f_min_addr, 1500);
      chk("t6_1608_unread", f_seen[1608], 0);
      chk("t6_done_pulses", f_done_n - d0, 1);
      chk("t6_busy", f_busy, 0);
      chk("t6_q_empty", q_f.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
